program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Byte-stream loader that fills program memory through its programming write port (pgm/addr/data). It receives a framed image from a byte source (UART receiver or debug bridge) and packs STEP bytes per word. It writes words at consecutive addresses from 0 and holds the core in reset while loading. It reports completion or framing/checksum errors.

Parameters:
INSTR_ADDR_WIDTH, 20, word-address width of program memory; must match the memory instance.
STEP, 4, bytes per instruction word; word width is STEP*8.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; arms the loader and clears done/error
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data is valid
rx_ready  output  1  loader accepts a byte; transfer when rx_valid && rx_ready
pgm  output  1  memory write strobe, one cycle per word
addr  output  INSTR_ADDR_WIDTH  word address for the write
data  output  STEP*8  word to write
core_hold  output  1  keeps the CPU in reset while high
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse on successful completion
error  output  1  sticky error flag; cleared by start or reset

Behaviour:
- Frame format: SYNC_BYTE, CNT_LO, CNT_HI, then N = {CNT_HI,CNT_LO} words of STEP bytes each, then CHK. Each word is little-endian: its first byte goes to data[7:0]. CHK = 8-bit sum (mod 256) of all data bytes.
- States: IDLE, SYNC, CNT_LO, CNT_HI, DATA, WRITE, CHECK, ERROR.
- IDLE: rx_ready=0. start moves to SYNC, clears error, and resets addr, byte index and sum to 0.
- SYNC: rx_ready=1. A byte equal to SYNC_BYTE moves to CNT_LO; any other byte is discarded and the state stays SYNC.
- CNT_LO/CNT_HI: latch the count bytes. After CNT_HI: N==0 or N > 2**INSTR_ADDR_WIDTH moves to ERROR; otherwise go to DATA. Compare at width max(17, INSTR_ADDR_WIDTH+1).
- DATA: rx_ready=1. Each accepted byte goes into byte lane idx, idx increments and sum += byte. When the byte in lane STEP-1 is accepted, go to WRITE.
- WRITE (1 cycle): pgm=1 with the current addr and assembled data, rx_ready=0, idx resets to 0. Next cycle addr increments and the remaining count decrements. If remaining becomes 0, go to CHECK, otherwise DATA.
- Write latency: the last byte of a word is accepted in cycle T; pgm is high in cycle T+1 only.
- CHECK: rx_ready=1. Accepted byte == sum: done pulses for 1 cycle, then IDLE. Mismatch: ERROR. Words already written are not rolled back.
- ERROR: error=1, rx_ready=0, core_hold stays 1. Leaves only on start (re-arm to SYNC) or reset.
- core_hold = 1 in every state except IDLE, and is also 1 in ERROR.
- start while busy is ignored, except in ERROR.
- addr wraps only when N == 2**INSTR_ADDR_WIDTH: the final increment wraps to 0, and this is harmless because the frame ends.
- Reset, including mid-frame: state=IDLE and all outputs 0 (pgm, addr, data, rx_ready, core_hold, busy, done, error). Partial memory contents are left as-is.
- rx_valid low stalls any receive state indefinitely. There is no timeout.

Decomposition:
- Shared package holds the state enum (loader_state_t), the SYNC_BYTE default and the frame field order constants.
- One natural sub-module, loader_word_packer: byte-lane shift/index counter plus running checksum, with outputs word_full and word data.
- The FSM, address counter and remaining-count counter stay in program_loader.

Test Plan:
- Reset, then start, then bytes A5 02 00 13 00 00 00 93 00 10 00 CHK=B6 -> pgm at addr 0 with data 32'h00000013, pgm at addr 1 with 32'h00100093, one done pulse, core_hold falls, error=0.
- Garbage 00 FF before A5, same frame as above -> garbage discarded, identical writes and done.
- Correct frame but CHK=B7 -> both words written, error=1 and sticky, no done. A following start clears error.
- Count 00 00 -> immediate ERROR, no pgm. With INSTR_ADDR_WIDTH=5: count 21 00 (33) -> ERROR, count 20 00 (32) -> accepted, 32 writes, addr wraps to 0 at the end.
- rx_valid toggled randomly during a 3-word load -> writes at addr 0..2 only, each pgm exactly 1 cycle, rx_ready low during WRITE.
- reset asserted after 2 data bytes -> all outputs 0 the next cycle. A new start plus a full frame then loads correctly from addr 0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared types and constants for the byte-stream program loader.
// Holds the FSM state encoding, the default frame sync marker and the count-compare width helper.
package program_loader_pkg;

  // States are numbered in frame field order: SYNC, CNT_LO, CNT_HI, DATA, CHECK.
  typedef logic [2:0] loader_state_t;

  localparam loader_state_t S_IDLE   = 3'd0;
  localparam loader_state_t S_SYNC   = 3'd1;
  localparam loader_state_t S_CNT_LO = 3'd2;
  localparam loader_state_t S_CNT_HI = 3'd3;
  localparam loader_state_t S_DATA   = 3'd4;
  localparam loader_state_t S_WRITE  = 3'd5;
  localparam loader_state_t S_CHECK  = 3'd6;
  localparam loader_state_t S_ERROR  = 3'd7;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // The 16-bit count is compared against 2**aw without overflow.
  function automatic int cnt_width(input int aw);
    return (aw + 1 > 17) ? aw + 1 : 17;
  endfunction

endpackage

// File: rtl/loader_word_packer.sv
// loader_word_packer: packs bytes little-endian into a STEP-byte word and keeps an 8-bit running sum.
// Ports: clk, reset, clear (restart frame), byte_en/byte_data in; word_full, word, sum out.
module loader_word_packer #(
  parameter int STEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_data,
  output logic              word_full,
  output logic [STEP*8-1:0] word,
  output logic [7:0]        sum
);

  localparam int IW = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [IW-1:0] LAST = IW'(STEP - 1);

  logic [IW-1:0] idx;

  // High in the cycle the byte for the top lane is accepted.
  assign word_full = byte_en && (idx == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      word <= '0;
      sum  <= '0;
    end else if (clear) begin
      idx <= '0;
      sum <= '0;
    end else if (byte_en) begin
      for (int i = 0; i < STEP; i++) begin
        if (idx == IW'(i)) word[i*8 +: 8] <= byte_data;
      end
      sum <= sum + byte_data;
      idx <= (idx == LAST) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// program_loader: receives a framed image (A5, cnt, words, chk) and writes it to program memory.
// Ports: rx_* byte input, pgm/addr/data write port, core_hold/busy/done/error status, start arm.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         INSTR_ADDR_WIDTH = 20,
  parameter int         STEP             = 4,
  parameter logic [7:0] SYNC_BYTE        = SYNC_BYTE_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic                        pgm,
  output logic [INSTR_ADDR_WIDTH-1:0] addr,
  output logic [STEP*8-1:0]           data,
  output logic                        core_hold,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam int AW = INSTR_ADDR_WIDTH;
  localparam int CW = cnt_width(AW);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] MAX_WORDS = ONE << AW;

  loader_state_t state;
  logic [7:0]    cnt_lo;
  logic [CW-1:0] remaining;
  logic [CW-1:0] n_words;
  logic          take;
  logic          start_ok;
  logic          word_full;
  logic [7:0]    sum;

  assign take     = rx_valid && rx_ready;
  assign start_ok = start && (state == S_IDLE || state == S_ERROR);
  assign n_words  = CW'({rx_data, cnt_lo});

  always_comb begin
    rx_ready = 1'b0;
    unique case (state)
      S_SYNC, S_CNT_LO, S_CNT_HI,
      S_DATA, S_CHECK: rx_ready = 1'b1;
      default:         rx_ready = 1'b0;
    endcase
  end

  assign pgm       = (state == S_WRITE);
  assign busy      = (state != S_IDLE);
  assign core_hold = busy;
  assign error     = (state == S_ERROR);

  loader_word_packer #(
    .STEP(STEP)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok),
    .byte_en  (take && state == S_DATA),
    .byte_data(rx_data),
    .word_full(word_full),
    .word     (data),
    .sum      (sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      cnt_lo    <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        state <= S_SYNC;
        addr  <= '0;
      end else begin
        unique case (state)
          S_SYNC: begin
            if (take && rx_data == SYNC_BYTE)
              state <= S_CNT_LO;
          end
          S_CNT_LO: begin
            if (take) begin
              cnt_lo <= rx_data;
              state  <= S_CNT_HI;
            end
          end
          S_CNT_HI: begin
            if (take) begin
              remaining <= n_words;
              if (n_words == '0 || n_words > MAX_WORDS)
                state <= S_ERROR;
              else
                state <= S_DATA;
            end
          end
          S_DATA: begin
            if (word_full) state <= S_WRITE;
          end
          S_WRITE: begin
            // With a full 2**AW image the last increment wraps to 0.
            addr      <= addr + AW'(1);
            remaining <= remaining - ONE;
            state     <= (remaining == ONE) ? S_CHECK : S_DATA;
          end
          S_CHECK: begin
            if (take) begin
              if (rx_data == sum) begin
                done  <= 1'b1;
                state <= S_IDLE;
              end else begin
                state <= S_ERROR;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed bench for program_loader with INSTR_ADDR_WIDTH=5.
// Drives framed images, logs pgm writes from a monitor and checks status flags.
module tb_program_loader;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          pgm;
  logic [AW-1:0] addr;
  logic [31:0]   data;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          error;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = -10;
  int done_cnt = 0;
  logic prev_pgm = 1'b0;

  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];

  logic [31:0] f1[$] = '{32'h00000013, 32'h00100093};
  logic [31:0] f3[$] = '{32'hDEADBEEF, 32'h12345678, 32'h0000FFFF};
  logic [31:0] f32[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  program_loader #(
    .INSTR_ADDR_WIDTH(AW),
    .STEP(4),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .pgm      (pgm),
    .addr     (addr),
    .data     (data),
    .core_hold(core_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pgm) begin
      wa.push_back(addr);
      wd.push_back(data);
      check("rdy_in_write", {63'd0, rx_ready}, 64'd0);
      check("pgm_width", {63'd0, prev_pgm}, 64'd0);
      check("wr_latency", 64'(cyc), 64'(acc_cyc + 1));
    end
    if (done) done_cnt++;
    if (rx_valid && rx_ready) acc_cyc = cyc;
    prev_pgm = pgm;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    repeat (gap) @(posedge clk);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    k = 0;
    while (!rx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rx_ready_wait", {63'd0, rx_ready}, 64'd1);
    if (rx_ready) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w[$],
                            input int garbage,
                            input logic [7:0] chk_add,
                            input int rnd);
    logic [7:0]  s;
    logic [15:0] n;
    logic [31:0] cur;
    logic [7:0]  b;
    s = 8'd0;
    n = 16'(w.size());
    if (garbage != 0) begin
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
    end
    send_byte(8'hA5, 0);
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
    for (int i = 0; i < w.size(); i++) begin
      cur = w[i];
      for (int j = 0; j < 4; j++) begin
        b = cur[8*j +: 8];
        s = s + b;
        send_byte(b, (rnd != 0) ? int'($urandom_range(0, 3)) : 0);
      end
    end
    send_byte(s + chk_add, 0);
  endtask

  task automatic check_writes(input logic [31:0] w[$], input string tag);
    check({tag, "_nwr"}, 64'(wa.size()), 64'(w.size()));
    for (int i = 0; i < wa.size() && i < w.size(); i++) begin
      check({tag, "_addr"}, 64'(wa[i]), 64'(i % (1 << AW)));
      check({tag, "_data"}, 64'(wd[i]), 64'(w[i]));
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    done_cnt = 0;
  endtask

  task automatic check_done_ok(input string tag);
    @(negedge clk);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_hold"}, {63'd0, core_hold}, 64'd0);
    check({tag, "_err"}, {63'd0, error}, 64'd0);
    @(negedge clk);
    check({tag, "_done1"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    for (int i = 0; i < 32; i++)
      f32.push_back(32'h01020300 + 32'(i));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs",
          64'({pgm, addr, data, rx_ready, core_hold, busy, done, error}),
          64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Basic two-word image.
    clear_log();
    pulse_start();
    @(negedge clk);
    check("t1_busy", 64'({busy, core_hold, rx_ready}), 64'b111);
    send_frame(f1, 0, 8'd0, 0);
    check_done_ok("t1");
    check_writes(f1, "t1");
    check("t1_ndone", 64'(done_cnt), 64'd1);

    // Garbage before the sync marker.
    clear_log();
    pulse_start();
    send_frame(f1, 1, 8'd0, 0);
    check_done_ok("t2");
    check_writes(f1, "t2");

    // Bad checksum: words stay written, error is sticky.
    clear_log();
    pulse_start();
    send_frame(f1, 0, 8'd1, 0);
    @(negedge clk);
    check("t3_err", {63'd0, error}, 64'd1);
    check("t3_done", {63'd0, done}, 64'd0);
    repeat (4) @(negedge clk);
    check("t3_sticky", 64'({error, rx_ready, core_hold}), 64'b101);
    check_writes(f1, "t3");
    check("t3_ndone", 64'(done_cnt), 64'd0);
    pulse_start();
    @(negedge clk);
    check("t3_rearm", 64'({error, busy, rx_ready}), 64'b011);
    clear_log();
    send_frame(f1, 0, 8'd0, 0);
    check_done_ok("t3b");
    check_writes(f1, "t3b");

    // Count boundaries.
    clear_log();
    pulse_start();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    check("t4_zero_err", {63'd0, error}, 64'd1);
    pulse_start();
    send_byte(8'hA5, 0);
    send_byte(8'h21, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    check("t4_33_err", {63'd0, error}, 64'd1);
    check("t4_nwr", 64'(wa.size()), 64'd0);
    pulse_start();
    send_frame(f32, 0, 8'd0, 0);
    check_done_ok("t4");
    check_writes(f32, "t4");
    check("t4_wrap", 64'(addr), 64'd0);

    // Random rx_valid gaps.
    clear_log();
    pulse_start();
    send_frame(f3, 0, 8'd0, 1);
    check_done_ok("t5");
    check_writes(f3, "t5");

    // Reset in the middle of a word.
    clear_log();
    pulse_start();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_reset_outs",
          64'({pgm, addr, data, rx_ready, core_hold, busy, done, error}),
          64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    pulse_start();
    send_frame(f1, 0, 8'd0, 0);
    check_done_ok("t6");
    check_writes(f1, "t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
